// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered, write-bypassed reads and a sweep-based clear.
// Latency: reads 1 cycle. A clear keeps busy high for DEPTH cycles after clr falls.
// No backpressure: writes are ignored and reads return zero while busy. Optional REGFILE_ZERO_REG_EN makes entry 0 read as zero.
module regfile_param #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              sweep_wr, norm_wr;
    logic              waddr_ok, raddr1_ok, raddr2_ok;
    logic [WIDTH-1:0]  rd1_nxt, rd2_nxt;

    // Entry 0 is treated as out of range when it is hardwired to zero.
    assign waddr_ok  = ({1'b0, waddr}  < DEPTH_V) && !(ZERO_REG && waddr  == '0);
    assign raddr1_ok = ({1'b0, raddr1} < DEPTH_V) && !(ZERO_REG && raddr1 == '0);
    assign raddr2_ok = ({1'b0, raddr2} < DEPTH_V) && !(ZERO_REG && raddr2 == '0);

    always_ff @(posedge clk) begin
        if (clr) state <= SWEEP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == SWEEP && ptr == LAST) state_nxt = IDLE;
    end

    always_comb begin
        busy     = (state == SWEEP);
        sweep_wr = (state == SWEEP) && !clr;
        norm_wr  = (state == IDLE) && !clr && we && waddr_ok;
    end

    always_ff @(posedge clk) begin
        if (clr)                ptr <= '0;
        else if (state == SWEEP) ptr <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (sweep_wr)     mem[ptr]   <= '0;
        else if (norm_wr) mem[waddr] <= wdata;
    end

    // Same-edge write to the read address forwards wdata instead of the stale entry.
    always_comb begin
        rd1_nxt = '0;
        rd2_nxt = '0;
        if (state == IDLE && raddr1_ok)
            rd1_nxt = (we && waddr_ok && waddr == raddr1) ? wdata : mem[raddr1];
        if (state == IDLE && raddr2_ok)
            rd2_nxt = (we && waddr_ok && waddr == raddr2) ? wdata : mem[raddr2];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (re) begin
            rdata1 <= rd1_nxt;
            rdata2 <= rd2_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a DEPTH=8 and a DEPTH=6 instance share stimulus and are
// checked against an array-based reference model of the register file.
module tb_regfile_param;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0, we = 1'b0, re = 1'b0;
    logic [2:0] waddr = '0, raddr1 = '0, raddr2 = '0;
    logic [7:0] wdata = '0;
    logic [7:0] r1_8, r2_8, r1_6, r2_6;
    logic       busy8, busy6;

    logic [7:0] got1 [2];
    logic [7:0] got2 [2];
    logic       gotb [2];
    assign got1[0] = r1_8;  assign got1[1] = r1_6;
    assign got2[0] = r2_8;  assign got2[1] = r2_6;
    assign gotb[0] = busy8; assign gotb[1] = busy6;

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 = DEPTH 8, index 1 = DEPTH 6
    int         dep   [2] = '{8, 6};
    logic [7:0] mem   [2][8];
    logic [7:0] e1    [2];
    logic [7:0] e2    [2];
    int         sleft [2];

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(8), .DEPTH(8)) u8 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1_8), .rdata2(r2_8), .busy(busy8));

    regfile_param #(.WIDTH(8), .DEPTH(6)) u6 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1_6), .rdata2(r2_6), .busy(busy6));

    // value an address holds once this edge's write has landed
    function automatic logic [7:0] view(int k, int a, bit wr_ok);
        if (a >= dep[k] || (ZERO && a == 0)) return 8'h00;
        if (wr_ok && int'(waddr) == a)       return wdata;
        return mem[k][a];
    endfunction

    function automatic void model_edge(int k);
        bit wr_ok;
        if (clr) begin
            sleft[k] = dep[k];
            e1[k] = 8'h00;
            e2[k] = 8'h00;
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
            return;
        end
        if (sleft[k] > 0) begin
            if (re) begin
                e1[k] = 8'h00;
                e2[k] = 8'h00;
            end
            sleft[k]--;
            return;
        end
        wr_ok = we && (int'(waddr) < dep[k]) && !(ZERO && waddr == 3'd0);
        if (re) begin
            e1[k] = view(k, int'(raddr1), wr_ok);
            e2[k] = view(k, int'(raddr2), wr_ok);
        end
        if (wr_ok) mem[k][waddr] = wdata;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; we = 0; re = 0; waddr = 0; raddr1 = 0; raddr2 = 0; wdata = 0;
    endtask

    task automatic test_reset();
        int cnt [2];
        clr = 1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gotb[k] !== 1'b1 || got1[k] !== 8'h00 || got2[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_state dut%0d: busy=%b rd1=%h rd2=%h, want busy=1 rd=00", k, gotb[k], got1[k], got2[k]);
            end
        end
        clr = 0;
        cnt = '{0, 0};
        for (int i = 1; i <= 20; i++) begin
            tick();
            for (int k = 0; k < 2; k++)
                if (cnt[k] == 0 && gotb[k] === 1'b0) cnt[k] = i;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt[k] != dep[k]) begin
                errors++;
                $display("FAIL sweep_len dut%0d: busy fell after %0d edges, want %0d", k, cnt[k], dep[k]);
            end
        end
        re = 1;
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a);
            raddr2 = 3'(7 - a);
            tick();
            checks++;
            if (r1_8 !== 8'h00 || r2_8 !== 8'h00) begin
                errors++;
                $display("FAIL cleared_read addr %0d: rd1=%h rd2=%h, want 00", a, r1_8, r2_8);
            end
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        we = 1; waddr = 3; wdata = 8'hA5;
        tick();
        we = 0; re = 1; raddr1 = 3; raddr2 = 5;
        tick();
        checks++;
        if (r1_8 !== 8'hA5 || r2_8 !== 8'h00) begin
            errors++;
            $display("FAIL latency: rd1=%h rd2=%h, want A5 00", r1_8, r2_8);
        end
        re = 0; raddr1 = 0; raddr2 = 1;
        tick();
        checks++;
        if (r1_8 !== 8'hA5 || r2_8 !== 8'h00) begin
            errors++;
            $display("FAIL hold: rd1=%h rd2=%h, want A5 00", r1_8, r2_8);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        we = 1; waddr = 6; wdata = 8'h3C; re = 1; raddr1 = 6; raddr2 = 6;
        tick();
        checks++;
        if (r1_8 !== 8'h3C || r2_8 !== 8'h3C) begin
            errors++;
            $display("FAIL bypass: rd1=%h rd2=%h, want 3C 3C", r1_8, r2_8);
        end
        checks++;
        if (r1_6 !== 8'h00 || r2_6 !== 8'h00) begin
            errors++;
            $display("FAIL bypass_oor dut6: rd1=%h rd2=%h, want 00 00", r1_6, r2_6);
        end
        idle_inputs();
    endtask

    task automatic test_write_during_sweep();
        int n;
        we = 1; waddr = 2; wdata = 8'h5A;
        tick();
        clr = 1; we = 0;
        tick();
        clr = 0; we = 1; waddr = 2; wdata = 8'hFF;
        tick();
        we = 0;
        n = 0;
        while ((busy8 !== 1'b0 || busy6 !== 1'b0) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL sweep_timeout: busy8=%b busy6=%b still high, want 0", busy8, busy6);
        end
        re = 1; raddr1 = 2; raddr2 = 2;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got1[k] !== 8'h00 || got2[k] !== 8'h00) begin
                errors++;
                $display("FAIL sweep_write dut%0d: rd1=%h rd2=%h, want 00", k, got1[k], got2[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        for (int a = 0; a < 6; a++) begin
            we = 1; waddr = 3'(a); wdata = 8'(8'h20 + a);
            tick();
        end
        waddr = 7; wdata = 8'h11;
        tick();
        we = 0; re = 1;
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a);
            raddr2 = 3'(a);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got1[k] !== e1[k] || got2[k] !== e2[k]) begin
                    errors++;
                    $display("FAIL oor_read dut%0d addr %0d: rd1=%h rd2=%h, want %h %h", k, a, got1[k], got2[k], e1[k], e2[k]);
                end
            end
        end
        raddr1 = 7;
        tick();
        checks++;
        if (r1_6 !== 8'h00) begin
            errors++;
            $display("FAIL oor_addr7 dut6: rd1=%h, want 00", r1_6);
        end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        logic [7:0] want;
        want = ZERO ? 8'h00 : 8'h77;
        we = 1; waddr = 0; wdata = 8'h77; re = 1; raddr1 = 0; raddr2 = 1;
        tick();
        checks++;
        if (r1_8 !== want) begin
            errors++;
            $display("FAIL zero_bypass: rd1=%h, want %h", r1_8, want);
        end
        we = 0; re = 0;
        tick();
        re = 1; raddr1 = 0;
        tick();
        checks++;
        if (r1_8 !== want || r1_6 !== want) begin
            errors++;
            $display("FAIL zero_later: rd1_8=%h rd1_6=%h, want %h", r1_8, r1_6, want);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr    = ($urandom_range(0, 59) == 0);
            we     = 1'($urandom_range(0, 1));
            re     = ($urandom_range(0, 3) != 0);
            waddr  = 3'($urandom_range(0, 7));
            raddr1 = 3'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            wdata  = 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got1[k] !== e1[k] || got2[k] !== e2[k] || gotb[k] !== (sleft[k] > 0)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d: rd1=%h rd2=%h busy=%b, want %h %h %b",
                             k, i, got1[k], got2[k], gotb[k], e1[k], e2[k], sleft[k] > 0);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_latency();
        test_bypass();
        test_write_during_sweep();
        test_out_of_range();
        test_zero_reg();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised 2-read/1-write register file. Successor to the fixed 3-bit-address, 8-bit-data regfile in the datapath.
- Read ports are registered and have write-to-read bypass.
- Clear is a multi-cycle sweep FSM, so storage scales to large DEPTH without a per-entry reset.
- Sits between the instruction decoder (addresses, write enable) and the ALU (operands).

Parameters:
- WIDTH, 8, data width of each entry in bits.
- DEPTH, 8, number of entries; need not be a power of two.
- ADDR_W, $clog2(DEPTH) (minimum 1), address width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high; starts the clear sweep.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- re  input  1  read enable, common to both read ports.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  WIDTH  read port 1 data, registered.
- rdata2  output  WIDTH  read port 2 data, registered.
- busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset / clear:
  - clr=1 at a rising edge forces state to SWEEP, ptr to 0, rdata1 and rdata2 to 0, and busy to 1.
  - Holding clr high keeps ptr at 0; no entries are cleared while clr is high.
- States:
  - IDLE: normal operation.
  - SWEEP: each edge with clr=0 writes mem[ptr]<=0 and increments ptr.
  - When ptr==DEPTH-1 is written, the next state is IDLE and busy falls after that edge.
  - busy is therefore high for exactly DEPTH edges after the first edge with clr=0.
- During SWEEP:
  - we is ignored.
  - re=1 loads 0 into both rdata ports.
  - re=0 holds the rdata ports.
- Write (IDLE):
  - we=1 and waddr<DEPTH: mem[waddr]<=wdata at the rising edge.
  - waddr>=DEPTH: the write is dropped silently.
- Read (IDLE):
  - Latency is 1 cycle.
  - re=1: rdataN <= mem[raddrN] at the edge.
  - re=0: rdataN holds its previous value.
  - raddrN>=DEPTH returns 0.
- Bypass:
  - Applies when re=1, we=1, waddr==raddrN and the address is in range.
  - rdataN <= wdata from the same edge, so the new data is seen, not the stale entry.
  - Both ports may bypass simultaneously.
- Reads do not depend on each other; raddr1==raddr2 is legal and returns identical data.
- clr asserted mid-sweep restarts the sweep at ptr=0.
- clr has priority over we and re in all states.
- Storage is written only on the rising edge; there is no negedge logic.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to zero.
  - Writes to waddr=0 are dropped.
  - Reads of address 0 return 0, with no bypass from address 0.
  - The sweep still runs for DEPTH cycles for timing uniformity.
- Undefined: entry 0 is an ordinary read/write entry.

Test Plan:
- Clear:
  - Stimulus: DEPTH=8. clr=1 for 2 cycles, then 0.
  - Required: busy=1 for exactly 8 edges after clr falls, then 0. Reads of all 8 addresses afterwards return 0x00.
- Write/read latency:
  - Stimulus: we waddr=3 wdata=0xA5, then next cycle re raddr1=3 raddr2=5.
  - Required: one edge later rdata1=0xA5 and rdata2=0x00. With re=0 on the following cycle, both hold.
- Bypass:
  - Stimulus: same cycle we waddr=6 wdata=0x3C, re raddr1=6 raddr2=6.
  - Required: next edge rdata1=rdata2=0x3C.
- Write during sweep:
  - Stimulus: we waddr=2 wdata=0xFF issued on the cycle after clr falls.
  - Required: the write is dropped; after busy falls, a read of address 2 returns 0x00.
- Out of range:
  - Stimulus: DEPTH=6, we waddr=7 wdata=0x11, then read addresses 7 and 0..5.
  - Required: address 7 returns 0, and addresses 0..5 are unchanged.
- REGFILE_ZERO_REG_EN:
  - Stimulus: we waddr=0 wdata=0x77, re raddr1=0 in the same cycle.
  - Required: rdata1=0x00 now and on a later read.
  - Without the macro, the same stimulus gives rdata1=0x77.
